// File: rtl/fp_multiplier_pkg.sv
// Shared types, constants and IEEE-754 single-precision field helpers for the
// sequential FP multiplier.
package fp_multiplier_pkg;

  localparam int          FP_EXP_BIAS = 127;
  localparam int          CNT_W       = 5;
  localparam logic [31:0] FP_NAN      = 32'h7FC0_0000;
  localparam logic [31:0] FP_ZERO     = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_NORM = 3'd2,
    S_DONE = 3'd3,
    S_RND  = 3'd4
  } state_e;

  typedef struct packed {
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
  } pack_t;

  function automatic logic fp_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [7:0] fp_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [23:0] fp_mant_full(input logic [31:0] x);
    return {1'b1, x[22:0]};
  endfunction

  function automatic logic is_zero(input logic [31:0] x);
    return (x[30:23] == 8'h00) && (x[22:0] == 23'd0);
  endfunction

  function automatic logic is_denorm(input logic [31:0] x);
    return (x[30:23] == 8'h00) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic [31:0] fp_inf(input logic sign);
    return {sign, 8'hFF, 23'd0};
  endfunction

  // Range-check a biased exponent and assemble the final word.
  function automatic pack_t fp_pack(input logic sign, input logic signed [9:0] exp,
                                    input logic [22:0] mant);
    pack_t p;
    p.result    = FP_ZERO;
    p.overflow  = 1'b0;
    p.underflow = 1'b0;
    if (exp >= 10'sd255) begin
      p.result   = fp_inf(sign);
      p.overflow = 1'b1;
    end else if (exp <= 10'sd0) begin
      p.result    = FP_ZERO;
      p.underflow = 1'b1;
    end else begin
      p.result = {sign, exp[7:0], mant};
    end
    return p;
  endfunction

endpackage

// File: rtl/fp_multiplier_if.sv
// Operand/result bundle for the FP multiplier; master is the sequencer side,
// slave is the multiplier.
interface fp_multiplier_if;
  logic [31:0] a;
  logic [31:0] b;
  logic        start;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        invalid;
  logic        overflow;
  logic        underflow;

  modport master (output a, b, start,
                  input  result, done, busy, invalid, overflow, underflow);
  modport slave  (input  a, b, start,
                  output result, done, busy, invalid, overflow, underflow);
endinterface

// File: rtl/fp_mant_mult_iter.sv
// 24x24 unsigned shift-add multiplier consuming BITS_PER_CYCLE multiplier bits
// per cycle; go loads the operands, rdy is high once all N steps are done.
module fp_mant_mult_iter #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [23:0] x,
  input  logic [23:0] y,
  output logic [47:0] prod,
  output logic        rdy
);
  import fp_multiplier_pkg::*;

  localparam int N = 24 / BITS_PER_CYCLE;

  logic [47:0]      r_acc;
  logic [47:0]      r_mcand;
  logic [23:0]      r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic [47:0]      w_partial;

  // Sum of the shifted multiplicand copies selected by the current multiplier LSBs.
  always_comb begin
    w_partial = 48'd0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_mplier[i]) begin
        w_partial = w_partial + (r_mcand << i);
      end else begin
        w_partial = w_partial;
      end
    end
  end

  // Operand load and iteration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc    <= 48'd0;
      r_mcand  <= 48'd0;
      r_mplier <= 24'd0;
      r_cnt    <= '0;
    end else if (go) begin
      r_acc    <= 48'd0;
      r_mcand  <= {24'd0, x};
      r_mplier <= y;
      r_cnt    <= CNT_W'(N);
    end else if (r_cnt != '0) begin
      r_acc    <= r_acc + w_partial;
      r_mcand  <= r_mcand << BITS_PER_CYCLE;
      r_mplier <= r_mplier >> BITS_PER_CYCLE;
      r_cnt    <= r_cnt - CNT_W'(1);
    end
  end

  assign prod = r_acc;
  assign rdy  = (r_cnt == '0);

endmodule

// File: rtl/fp_multiplier.sv
// Sequential IEEE-754 single-precision multiplier with level start/done handshake.
// Define FP_MUL_ROUND_NEAREST_EN for round-to-nearest-even (one extra NORM cycle).
module fp_multiplier
  import fp_multiplier_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1,
  parameter int EXP_BIAS       = FP_EXP_BIAS
) (
  input logic             clk,
  input logic             reset,
  fp_multiplier_if.slave  io_bus
);

  localparam int N = 24 / BITS_PER_CYCLE;

  state_e            r_state, w_state_nxt;
  logic              r_sign, w_sign_nxt, w_sign;
  logic signed [9:0] r_exp, w_exp_nxt, w_exp_sum, w_norm_exp, w_fin_exp;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [31:0]       r_result, w_result_nxt;
  logic              r_done, w_done_nxt;
  logic              r_busy;
  logic              r_invalid, w_invalid_nxt;
  logic              r_overflow, w_overflow_nxt;
  logic              r_underflow, w_underflow_nxt;
  logic              w_go, w_rdy;
  logic [23:0]       w_mant_a, w_mant_b;
  logic [47:0]       w_prod;
  logic [22:0]       w_norm_mant, w_fin_mant;
  logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic              w_unused_prod;
  pack_t             w_pack;
`ifdef FP_MUL_ROUND_NEAREST_EN
  logic [24:0]       r_rmant, w_rmant_nxt, w_rmant_sum;
  logic              w_guard, w_sticky;
`endif

  // Denormals are flushed, so they classify as zero.
  assign w_a_zero = is_zero(io_bus.a) | is_denorm(io_bus.a);
  assign w_b_zero = is_zero(io_bus.b) | is_denorm(io_bus.b);
  assign w_a_inf  = is_inf(io_bus.a);
  assign w_b_inf  = is_inf(io_bus.b);
  assign w_a_nan  = is_nan(io_bus.a);
  assign w_b_nan  = is_nan(io_bus.b);
  assign w_sign   = fp_sign(io_bus.a) ^ fp_sign(io_bus.b);
  assign w_exp_sum = {2'b00, fp_exp(io_bus.a)} + {2'b00, fp_exp(io_bus.b)} - 10'(EXP_BIAS);
  assign w_mant_a = fp_mant_full(io_bus.a);
  assign w_mant_b = fp_mant_full(io_bus.b);
  assign w_unused_prod = ^w_prod[22:0];

  fp_mant_mult_iter #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_mant (
    .clk   (clk),
    .reset (reset),
    .go    (w_go),
    .x     (w_mant_a),
    .y     (w_mant_b),
    .prod  (w_prod),
    .rdy   (w_rdy)
  );

  // Normalise the raw product (and, when enabled, form the rounded mantissa).
  always_comb begin
    if (w_prod[47]) begin
      w_norm_mant = w_prod[46:24];
      w_norm_exp  = r_exp + 10'sd1;
    end else begin
      w_norm_mant = w_prod[45:23];
      w_norm_exp  = r_exp;
    end
`ifdef FP_MUL_ROUND_NEAREST_EN
    if (w_prod[47]) begin
      w_guard  = w_prod[23];
      w_sticky = |w_prod[22:0];
    end else begin
      w_guard  = w_prod[22];
      w_sticky = |w_prod[21:0];
    end
    w_rmant_sum = {2'b01, w_norm_mant} + {24'd0, w_guard & (w_sticky | w_norm_mant[0])};
    if (r_rmant[24]) begin
      w_fin_exp  = r_exp + 10'sd1;
      w_fin_mant = r_rmant[23:1];
    end else begin
      w_fin_exp  = r_exp;
      w_fin_mant = r_rmant[22:0];
    end
`else
    w_fin_exp  = w_norm_exp;
    w_fin_mant = w_norm_mant;
`endif
    w_pack = fp_pack(r_sign, w_fin_exp, w_fin_mant);
  end

  // Next-state and next-datapath logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_sign_nxt      = r_sign;
    w_exp_nxt       = r_exp;
    w_cnt_nxt       = r_cnt;
    w_result_nxt    = r_result;
    w_done_nxt      = r_done;
    w_invalid_nxt   = r_invalid;
    w_overflow_nxt  = r_overflow;
    w_underflow_nxt = r_underflow;
    w_go            = 1'b0;
`ifdef FP_MUL_ROUND_NEAREST_EN
    w_rmant_nxt     = r_rmant;
`endif
    case (r_state)
      S_IDLE: begin
        w_done_nxt = 1'b0;
        if (io_bus.start) begin
          w_sign_nxt      = w_sign;
          w_exp_nxt       = w_exp_sum;
          w_cnt_nxt       = CNT_W'(N);
          w_invalid_nxt   = 1'b0;
          w_overflow_nxt  = 1'b0;
          w_underflow_nxt = 1'b0;
          if (w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_a_zero & w_b_inf)) begin
            w_result_nxt  = FP_NAN;
            w_invalid_nxt = 1'b1;
            w_done_nxt    = 1'b1;
            w_state_nxt   = S_DONE;
          end else if (w_a_zero | w_b_zero) begin
            w_result_nxt = FP_ZERO;
            w_done_nxt   = 1'b1;
            w_state_nxt  = S_DONE;
          end else if (w_a_inf | w_b_inf) begin
            w_result_nxt = fp_inf(w_sign);
            w_done_nxt   = 1'b1;
            w_state_nxt  = S_DONE;
          end else begin
            w_go        = 1'b1;
            w_state_nxt = S_MUL;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MUL: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_NORM;
        end else begin
          w_state_nxt = S_MUL;
        end
      end
      S_NORM: begin
        if (w_rdy) begin
`ifdef FP_MUL_ROUND_NEAREST_EN
          w_exp_nxt   = w_norm_exp;
          w_rmant_nxt = w_rmant_sum;
          w_state_nxt = S_RND;
`else
          w_result_nxt    = w_pack.result;
          w_overflow_nxt  = w_pack.overflow;
          w_underflow_nxt = w_pack.underflow;
          w_done_nxt      = 1'b1;
          w_state_nxt     = S_DONE;
`endif
        end else begin
          w_state_nxt = S_NORM;
        end
      end
`ifdef FP_MUL_ROUND_NEAREST_EN
      S_RND: begin
        w_result_nxt    = w_pack.result;
        w_overflow_nxt  = w_pack.overflow;
        w_underflow_nxt = w_pack.underflow;
        w_done_nxt      = 1'b1;
        w_state_nxt     = S_DONE;
      end
`endif
      S_DONE: begin
        if (!io_bus.start) begin
          w_done_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_done_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sign      <= 1'b0;
      r_exp       <= 10'sd0;
      r_cnt       <= '0;
      r_result    <= 32'd0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_invalid   <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
`ifdef FP_MUL_ROUND_NEAREST_EN
      r_rmant     <= 25'd0;
`endif
    end else begin
      r_sign      <= w_sign_nxt;
      r_exp       <= w_exp_nxt;
      r_cnt       <= w_cnt_nxt;
      r_result    <= w_result_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_invalid   <= w_invalid_nxt;
      r_overflow  <= w_overflow_nxt;
      r_underflow <= w_underflow_nxt;
`ifdef FP_MUL_ROUND_NEAREST_EN
      r_rmant     <= w_rmant_nxt;
`endif
    end
  end

  assign io_bus.result    = r_result;
  assign io_bus.done      = r_done;
  assign io_bus.busy      = r_busy;
  assign io_bus.invalid   = r_invalid;
  assign io_bus.overflow  = r_overflow;
  assign io_bus.underflow = r_underflow;

endmodule

// File: tb/tb_fp_multiplier.sv
// Scoreboard bench for fp_multiplier: directed and random operands checked
// against an integer-arithmetic reference model.
module tb_fp_multiplier;

  localparam int BPC = 1;
  localparam int N   = 24 / BPC;
`ifdef FP_MUL_ROUND_NEAREST_EN
  localparam int NORM_LAT = N + 3;
  localparam bit RND      = 1'b1;
`else
  localparam int NORM_LAT = N + 2;
  localparam bit RND      = 1'b0;
`endif

  typedef struct {
    logic [31:0] res;
    logic        inv;
    logic        ovf;
    logic        unf;
    int          lat;
    int          acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sbq[$];
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  fp_multiplier_if bus();

  fp_multiplier #(.BITS_PER_CYCLE(BPC), .EXP_BIAS(127)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Reference: classify operands, multiply significands as integers, normalise.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    int     ea, eb, eo, sh;
    longint ma, mb, p, full, rem, half;
    bit     za, zb, ia, ib, na, nb, s;
    logic [63:0] fv;
    e.res = 32'd0; e.inv = 1'b0; e.ovf = 1'b0; e.unf = 1'b0; e.lat = 1; e.acc_cyc = 0;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    na = (ea == 255) && (a[22:0] != 23'd0);
    nb = (eb == 255) && (b[22:0] != 23'd0);
    ia = (ea == 255) && (a[22:0] == 23'd0);
    ib = (eb == 255) && (b[22:0] == 23'd0);
    za = (ea == 0);
    zb = (eb == 0);
    s  = a[31] ^ b[31];
    if (na || nb || (ia && zb) || (za && ib)) begin
      e.res = 32'h7FC0_0000; e.inv = 1'b1;
    end else if (za || zb) begin
      e.res = 32'd0;
    end else if (ia || ib) begin
      e.res = {s, 8'hFF, 23'd0};
    end else begin
      e.lat = NORM_LAT;
      ma = longint'({1'b1, a[22:0]});
      mb = longint'({1'b1, b[22:0]});
      p  = ma * mb;
      eo = ea + eb - 127;
      if (p >= (64'sd1 <<< 47)) begin sh = 24; eo++; end
      else sh = 23;
      full = p >>> sh;
      rem  = p - (full <<< sh);
      half = 64'sd1 <<< (sh - 1);
      if (RND && ((rem > half) || ((rem == half) && (full % 2 == 1)))) begin
        full++;
        if (full == (64'sd1 <<< 24)) begin full = full >>> 1; eo++; end
      end
      fv = 64'(full);
      if (eo >= 255) begin
        e.res = {s, 8'hFF, 23'd0}; e.ovf = 1'b1;
      end else if (eo <= 0) begin
        e.res = 32'd0; e.unf = 1'b1;
      end else begin
        e.res = {s, 8'(eo), fv[22:0]};
      end
    end
    return e;
  endfunction

  // Monitor: on each rising done, pop and compare.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.done && !prev_done) begin
      if (sbq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: got done=1 with no pending operation");
      end else begin
        e = sbq.pop_front();
        chk("result", bus.result, e.res);
        chk("invalid", {31'd0, bus.invalid}, {31'd0, e.inv});
        chk("overflow", {31'd0, bus.overflow}, {31'd0, e.ovf});
        chk("underflow", {31'd0, bus.underflow}, {31'd0, e.unf});
        chk("latency", 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
      end
    end
    prev_done = bus.done;
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold, input bit wiggle);
    exp_t e;
    int   t;
    bit   got;
    e = model(a, b);
    e.acc_cyc = cyc + 1;
    sbq.push_back(e);
    bus.a = a; bus.b = b; bus.start = 1'b1;
    t = 0; got = 1'b0;
    while (!got && t < 100) begin
      @(negedge clk); t++;
      if (t == 1) chk("busy", {31'd0, bus.busy}, 32'd1);
      if (bus.done) got = 1'b1;
      else begin
        bus.a = $urandom(); bus.b = $urandom();
        if (wiggle && t == 3) bus.start = 1'b0;
        if (wiggle && t == 6) bus.start = 1'b1;
      end
    end
    if (!got) begin
      n_chk++;
      $display("FAIL timeout: got no done after %0d cycles expected done", t);
      sbq.delete();
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.a = $urandom(); bus.b = $urandom();
      chk("hold_result", bus.result, e.res);
      chk("hold_done", {31'd0, bus.done}, 32'd1);
    end
    bus.start = 1'b0;
    @(negedge clk);
    chk("done_drop", {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    reset = 1'b1; bus.start = 1'b0; bus.a = 32'd0; bus.b = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_flags", {27'd0, bus.done, bus.busy, bus.invalid, bus.overflow, bus.underflow}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op(32'h4040_0000, 32'h4000_0000, 40, 1'b0);
    do_op(32'h3FC0_0000, 32'h3FC0_0000, 0, 1'b0);
    do_op(32'h7F00_0000, 32'h4000_0000, 0, 1'b0);
    do_op(32'h0080_0000, 32'h0080_0000, 0, 1'b0);
    do_op(32'h7F80_0000, 32'h0000_0000, 0, 1'b0);
    do_op(32'h7FC0_0000, 32'h3F80_0000, 0, 1'b0);
    do_op(32'hFF80_0000, 32'h4000_0000, 0, 1'b0);
    do_op(32'h3F80_0001, 32'h3FC0_0000, 0, 1'b0);
    do_op(32'h0000_1234, 32'h4000_0000, 0, 1'b0);
    do_op(32'hC0A0_0000, 32'h3F00_0000, 0, 1'b1);

    // Reset in the middle of MUL, then a clean operation.
    sbq.push_back(model(32'h4040_0000, 32'h4000_0000));
    bus.a = 32'h4040_0000; bus.b = 32'h4000_0000; bus.start = 1'b1;
    repeat (11) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_result", bus.result, 32'd0);
    chk("midrst_flags", {27'd0, bus.done, bus.busy, bus.invalid, bus.overflow, bus.underflow}, 32'd0);
    void'(sbq.pop_back());
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op(32'h4040_0000, 32'h4000_0000, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      case (i % 3)
        0: begin
          ra = {1'($urandom()), 8'($urandom_range(154, 100)), 23'($urandom())};
          rb = {1'($urandom()), 8'($urandom_range(154, 100)), 23'($urandom())};
        end
        1: begin
          ra = {1'($urandom()), 8'($urandom_range(254, 190)), 23'($urandom())};
          rb = {1'($urandom()), 8'($urandom_range(64, 1)), 23'($urandom())};
          if (i % 2 == 1) rb[30:23] = 8'($urandom_range(254, 190));
          else ra[30:23] = 8'($urandom_range(64, 1));
        end
        default: begin
          ra = $urandom(); rb = $urandom();
        end
      endcase
      do_op(ra, rb, 0, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fp_multiplier.md
Name: fp_multiplier

Overview:
- Sequential IEEE-754 single-precision multiplier for the floating-point ALU; it is the inverse operation of the FP divider.
- Same level start/done handshake as the divider, so the calculator sequencer drives both identically.
- Mantissa product is formed by an iterative shift-add over several cycles; special operands bypass the iteration.
- Results truncate by default; round-to-nearest-even is optional.

Parameters:
- BITS_PER_CYCLE, 1, multiplier bits consumed per MUL cycle. Legal values: 1, 2, 4, 8.
- EXP_BIAS, 127, exponent bias.

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- a  in  32  operand A, sampled only on the start-accept edge
- b  in  32  operand B, sampled only on the start-accept edge
- start  in  1  level request
- result  out  32  product
- done  out  1  result valid
- busy  out  1  high in LOAD/MUL/NORM/DONE
- invalid  out  1  NaN operand or inf*0
- overflow  out  1  exponent overflow
- underflow  out  1  exponent underflow

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- Reset (any time, including mid-MUL): state=IDLE; result=0, done=0, busy=0, invalid=0, overflow=0, underflow=0; all internal registers cleared.
- States: IDLE, MUL, NORM, DONE. Define N = 24/BITS_PER_CYCLE.
- IDLE:
  - done<=0.
  - On start=1: latch a and b, clear flags, load acc=0, multiplicand=mant_a, multiplier=mant_b, cnt=N.
  - Exponent: exp_tmp = exp_a + exp_b - EXP_BIAS, computed as 10-bit signed. Sign: sign_a ^ sign_b.
  - Special operands resolve on this same edge: write result, set done<=1, go to DONE. Priority:
    - NaN in either operand, or inf*0: result=7FC00000, invalid<=1.
    - Either operand zero: result=+0 (00000000).
    - Either operand inf: result={sign,FF,0}.
  - Denormal inputs (exp=0, mant!=0) are flushed to zero.
  - Otherwise go to MUL.
- MUL:
  - Each cycle adds the partial products of BITS_PER_CYCLE multiplier LSBs into a 48-bit acc, then shifts.
  - cnt decrements each cycle; after N cycles go to NORM.
- NORM (1 cycle):
  - If p[47]=1: mant=p[46:24], exp_tmp+1. Else: mant=p[45:23].
  - If exp_tmp >= 255: result={sign,FF,0}, overflow<=1.
  - Else if exp_tmp <= 0: result=+0, underflow<=1.
  - Else: result={sign,exp,mant}.
  - Set done<=1; go to DONE.
- Latency, start-accept edge to done=1: normal operands N+2 edges (26 with the default); special operands 1 edge.
- DONE:
  - result and flags are held stable while start=1; a and b are ignored.
  - The first edge with start=0 sets state=IDLE and done<=0.
  - start toggling during MUL/NORM has no effect.
- Flags stay valid until the next accepted start clears them.

Optional Feature:
- Macro: FP_MUL_ROUND_NEAREST_EN.
- Defined:
  - NORM applies round-to-nearest-even using guard = bit below the mantissa LSB and sticky = OR of all lower bits.
  - A mantissa carry-out renormalises (exp+1) before the overflow check.
  - This adds one NORM cycle, so normal latency becomes N+3.
- Undefined: pure truncation; latency N+2.

Decomposition:
- Existing shared fp_utils.v supplies FP_SIGN, FP_EXP, FP_MANT_FULL, IS_ZERO, IS_INF, FP_NAN, FP_ZERO.
- Add to fp_utils.v: IS_NAN, IS_DENORM, FP_INF(sign), FP_EXP_BIAS.
- One sub-module is natural: fp_mant_mult_iter, a 24x24 shift-add core.
  - Ports: clk, reset, go, x, y, prod[47:0], rdy.
  - Parameter: BITS_PER_CYCLE.
  - The top owns the state machine, special cases and normalisation.

Test Plan:
- 40400000 x 40000000 (3.0*2.0): result=40C00000, done on edge 26, all flags 0.
- 3FC00000 x 3FC00000 (1.5*1.5, p[47]=1 path): result=40100000.
- 7F000000 x 40000000: result=7F800000, overflow=1. 00800000 x 00800000: result=00000000, underflow=1.
- Special operands, each done after 1 edge:
  - 7F800000 x 00000000: 7FC00000, invalid=1.
  - 7FC00000 x 3F800000: 7FC00000, invalid=1.
  - FF800000 x 40000000: FF800000.
- Handshake and reset:
  - Hold start=1 for 40 cycles while changing a and b after accept: result and done stay stable.
  - Drop start: done=0 after 1 edge.
  - Assert reset at MUL cycle 10: all outputs 0 immediately. The next start computes correctly.
- 3F800001 x 3FC00000 (tie case):
  - Truncation build: 3FC00001.
  - FP_MUL_ROUND_NEAREST_EN build: 3FC00002, with done on edge 27.
